// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD bus decoder: FSM states, instruction
// opcode masks/values, display geometry and address-counter mapping helpers.
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_CLEAR = 2'd2
  } lcd_state_e;

  localparam int unsigned LCD_COLS   = 16;
  localparam int unsigned LCD_DEPTH  = 2 * LCD_COLS;
  localparam int unsigned LCD_IDX_W  = $clog2(LCD_DEPTH);
  localparam int unsigned LCD_BYTE_W = 8;

  localparam logic [7:0] LCD_LINE1_BASE = 8'h00;
  localparam logic [7:0] LCD_LINE2_BASE = 8'h40;
  localparam logic [7:0] LCD_SPACE      = 8'h20;

  localparam logic [7:0] OP_SETAC_MASK = 8'h80, OP_SETAC_VAL = 8'h80;
  localparam logic [7:0] OP_CGRAM_MASK = 8'hC0, OP_CGRAM_VAL = 8'h40;
  localparam logic [7:0] OP_FUNC_MASK  = 8'hE0, OP_FUNC_VAL  = 8'h20;
  localparam logic [7:0] OP_DISP_MASK  = 8'hF8, OP_DISP_VAL  = 8'h08;
  localparam logic [7:0] OP_ENTRY_MASK = 8'hFC, OP_ENTRY_VAL = 8'h04;
  localparam logic [7:0] OP_HOME_MASK  = 8'hFE, OP_HOME_VAL  = 8'h02;
  localparam logic [7:0] OP_CLEAR_MASK = 8'hFF, OP_CLEAR_VAL = 8'h01;

  function automatic logic op_match(input logic [7:0] b, input logic [7:0] mask,
                                    input logic [7:0] val);
    return (b & mask) == val;
  endfunction

  // Buffer index -> AC value: bit 4 of the index selects the line base.
  function automatic logic [6:0] idx_to_ac(input logic [LCD_IDX_W-1:0] idx);
    return (idx[4] ? LCD_LINE2_BASE[6:0] : LCD_LINE1_BASE[6:0]) | 7'(idx[3:0]);
  endfunction

  // Only 0x00-0x0F and 0x40-0x4F address visible cells.
  function automatic logic ac_legal(input logic [6:0] ac);
    return ac[5:4] == 2'b00;
  endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 32x8 display buffer: one synchronous write port, one registered read port
// (read-before-write on an address collision).
module lcd_ddram
  import lcd_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [LCD_IDX_W-1:0]  waddr_i,
  input  logic [LCD_BYTE_W-1:0] wdata_i,
  input  logic [LCD_IDX_W-1:0]  raddr_i,
  output logic [LCD_BYTE_W-1:0] rdata_o
);

  logic [LCD_BYTE_W-1:0] mem_q [LCD_DEPTH];
  logic [LCD_BYTE_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lcd_bus_decoder.sv
// LCD controller bus decoder: accepts instruction/data writes into a 2x16 buffer.
// Define LCD_BUSY_EMU_EN to emulate post-write busy time (BUSY_CYCLES).
module lcd_bus_decoder
  import lcd_pkg::*;
#(
  parameter int unsigned BUSY_CYCLES = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lcd_enb,
  input  logic                  lcd_rs,
  input  logic                  lcd_rw,
  input  logic [LCD_BYTE_W-1:0] lcd_data,
  output logic [LCD_BYTE_W-1:0] lcd_rdata,
  output logic                  lcd_rdata_oe,
  input  logic [LCD_IDX_W-1:0]  rd_addr,
  output logic [LCD_BYTE_W-1:0] rd_char,
  output logic                  cmd_valid,
  output logic                  cmd_rs,
  output logic [LCD_BYTE_W-1:0] cmd_byte,
  output logic                  disp_on,
  output logic                  busy_viol,
  output logic                  addr_err
);

  if (BUSY_CYCLES == 0) begin : g_bad_busy_cycles
    $error("BUSY_CYCLES must be at least 1");
  end

`ifdef LCD_BUSY_EMU_EN
  localparam int unsigned BCW = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
  logic [BCW-1:0] busy_cnt_q, busy_cnt_d;
`endif

  lcd_state_e state_q, state_d;
  logic [LCD_IDX_W-1:0]  idx_q, idx_d, clr_cnt_q, clr_cnt_d;
  logic                  id_q, id_d, cgram_q, cgram_d, disp_q, disp_d;
  logic                  viol_q, viol_d, aerr_q, aerr_d, enb_q;
  logic                  cmd_valid_q, cmd_valid_d, cmd_rs_q, cmd_rs_d;
  logic [LCD_BYTE_W-1:0] cmd_byte_q, cmd_byte_d;

  logic                  strobe_c, we_c, busy_c, rd_cycle_c;
  logic [LCD_IDX_W-1:0]  waddr_c;
  logic [LCD_BYTE_W-1:0] wdata_c;

  assign strobe_c = enb_q & ~lcd_enb & ~lcd_rw;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      idx_q       <= '0;
      clr_cnt_q   <= '0;
      id_q        <= 1'b1;
      cgram_q     <= 1'b0;
      disp_q      <= 1'b0;
      viol_q      <= 1'b0;
      aerr_q      <= 1'b0;
      enb_q       <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_rs_q    <= 1'b0;
      cmd_byte_q  <= '0;
`ifdef LCD_BUSY_EMU_EN
      busy_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      clr_cnt_q   <= clr_cnt_d;
      id_q        <= id_d;
      cgram_q     <= cgram_d;
      disp_q      <= disp_d;
      viol_q      <= viol_d;
      aerr_q      <= aerr_d;
      enb_q       <= lcd_enb;
      cmd_valid_q <= cmd_valid_d;
      cmd_rs_q    <= cmd_rs_d;
      cmd_byte_q  <= cmd_byte_d;
`ifdef LCD_BUSY_EMU_EN
      busy_cnt_q  <= busy_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    clr_cnt_d   = clr_cnt_q;
    id_d        = id_q;
    cgram_d     = cgram_q;
    disp_d      = disp_q;
    viol_d      = viol_q;
    aerr_d      = aerr_q;
    cmd_valid_d = 1'b0;
    cmd_rs_d    = cmd_rs_q;
    cmd_byte_d  = cmd_byte_q;
    we_c        = 1'b0;
    waddr_c     = idx_q;
    wdata_c     = lcd_data;
`ifdef LCD_BUSY_EMU_EN
    busy_cnt_d  = busy_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (strobe_c) begin
          cmd_valid_d = 1'b1;
          cmd_rs_d    = lcd_rs;
          cmd_byte_d  = lcd_data;
`ifdef LCD_BUSY_EMU_EN
          state_d     = ST_BUSY;
          busy_cnt_d  = BCW'(BUSY_CYCLES - 1);
`endif
          if (lcd_rs) begin
            // Natural 5-bit wrap gives the required line-to-line ordering.
            if (!cgram_q) begin
              we_c  = 1'b1;
              idx_d = id_q ? idx_q + 5'd1 : idx_q - 5'd1;
            end
          end else if (op_match(lcd_data, OP_SETAC_MASK, OP_SETAC_VAL)) begin
            cgram_d = 1'b0;
            if (ac_legal(lcd_data[6:0])) idx_d  = {lcd_data[6], lcd_data[3:0]};
            else                         aerr_d = 1'b1;
          end else if (op_match(lcd_data, OP_CGRAM_MASK, OP_CGRAM_VAL)) begin
            cgram_d = 1'b1;
          end else if (op_match(lcd_data, OP_FUNC_MASK, OP_FUNC_VAL)) begin
            cgram_d = cgram_q;
          end else if (op_match(lcd_data, OP_DISP_MASK, OP_DISP_VAL)) begin
            disp_d = lcd_data[2];
          end else if (op_match(lcd_data, OP_ENTRY_MASK, OP_ENTRY_VAL)) begin
            id_d = lcd_data[1];
          end else if (op_match(lcd_data, OP_HOME_MASK, OP_HOME_VAL)) begin
            idx_d = '0;
          end else if (op_match(lcd_data, OP_CLEAR_MASK, OP_CLEAR_VAL)) begin
            state_d   = ST_CLEAR;
            clr_cnt_d = '0;
            cgram_d   = 1'b0;
          end
        end
      end

      ST_CLEAR: begin
        if (strobe_c) viol_d = 1'b1;
        we_c    = 1'b1;
        waddr_c = clr_cnt_q;
        wdata_c = LCD_SPACE;
        if (clr_cnt_q == LCD_IDX_W'(LCD_DEPTH - 1)) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          id_d    = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + 5'd1;
        end
      end

`ifdef LCD_BUSY_EMU_EN
      ST_BUSY: begin
        if (strobe_c) viol_d = 1'b1;
        if (busy_cnt_q == '0) state_d    = ST_IDLE;
        else                  busy_cnt_d = busy_cnt_q - BCW'(1);
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  lcd_ddram u_ddram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (we_c),
    .waddr_i (waddr_c),
    .wdata_i (wdata_c),
    .raddr_i (rd_addr),
    .rdata_o (rd_char)
  );

  // Status read is combinational on the live bus; RS=1 reads drive zero.
  assign busy_c       = (state_q != ST_IDLE);
  assign rd_cycle_c   = lcd_enb & lcd_rw;
  assign lcd_rdata_oe = rd_cycle_c;
  assign lcd_rdata    = (rd_cycle_c && !lcd_rs) ? {busy_c, idx_to_ac(idx_q)} : 8'h00;

  assign cmd_valid = cmd_valid_q;
  assign cmd_rs    = cmd_rs_q;
  assign cmd_byte  = cmd_byte_q;
  assign disp_on   = disp_q;
  assign busy_viol = viol_q;
  assign addr_err  = aerr_q;

endmodule

// File: tb/tb_lcd_bus_decoder.sv
// Directed self-checking bench for lcd_bus_decoder; expectations follow the
// LCD_BUSY_EMU_EN build setting where busy emulation changes behaviour.
module tb_lcd_bus_decoder;

  localparam int unsigned BUSY = 40;
  localparam int unsigned GAP  = BUSY + 5;

`ifdef LCD_BUSY_EMU_EN
  localparam logic [7:0] EXP_C16   = 8'h5B;
  localparam logic [7:0] EXP_AC    = 8'h40;
  localparam logic [7:0] EXP_VIOL  = 8'h01;
  localparam int         EXP_PULSE = 1;
`else
  localparam logic [7:0] EXP_C16   = 8'h33;
  localparam logic [7:0] EXP_AC    = 8'h41;
  localparam logic [7:0] EXP_VIOL  = 8'h00;
  localparam int         EXP_PULSE = 2;
`endif

  logic       clk = 1'b0, rst = 1'b1;
  logic       lcd_enb = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
  logic [7:0] lcd_data = 8'h00;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] lcd_rdata, rd_char, cmd_byte;
  logic       lcd_rdata_oe, cmd_valid, cmd_rs, disp_on, busy_viol, addr_err;

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  int p0;

  lcd_bus_decoder #(.BUSY_CYCLES(BUSY)) dut (
    .clk(clk), .rst(rst), .lcd_enb(lcd_enb), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_data(lcd_data), .lcd_rdata(lcd_rdata), .lcd_rdata_oe(lcd_rdata_oe),
    .rd_addr(rd_addr), .rd_char(rd_char), .cmd_valid(cmd_valid), .cmd_rs(cmd_rs),
    .cmd_byte(cmd_byte), .disp_on(disp_on), .busy_viol(busy_viol), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (cmd_valid === 1'b1) pulses++;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic rs, input logic [7:0] d);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = 1'b0; lcd_data = d; lcd_enb = 1'b1;
    @(negedge clk);
    lcd_enb = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input logic rs, input logic [7:0] d);
    bus_write(rs, d);
    tick(GAP);
  endtask

  task automatic chk_char(input logic [4:0] a, input logic [7:0] e);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    chk($sformatf("char%0d", a), rd_char, e);
  endtask

  // Status read held only within one low phase so no edge ever registers it.
  task automatic chk_status(input string tag, input logic rs, input logic [7:0] e);
    @(negedge clk);
    lcd_enb = 1'b1; lcd_rw = 1'b1; lcd_rs = rs;
    #1;
    chk(tag, lcd_rdata, e);
    chk({tag, "_oe"}, 8'(lcd_rdata_oe), 8'h01);
    lcd_enb = 1'b0; lcd_rw = 1'b0; lcd_rs = 1'b0;
  endtask

  initial begin
    tick(3);
    chk("rst_cmd_valid", 8'(cmd_valid), 8'h00);
    chk("rst_cmd_byte", cmd_byte, 8'h00);
    chk("rst_cmd_rs", 8'(cmd_rs), 8'h00);
    chk("rst_busy_viol", 8'(busy_viol), 8'h00);
    chk("rst_addr_err", 8'(addr_err), 8'h00);
    chk("rst_disp_on", 8'(disp_on), 8'h00);
    chk("rst_rd_char", rd_char, 8'h00);
    chk("rst_rdata_oe", 8'(lcd_rdata_oe), 8'h00);

    // Post-reset clear: busy flag set, strobes are violations
    rst = 1'b0;
    chk_status("clr_busy", 1'b0, 8'h80);
    bus_write(1'b0, 8'h0C);
    tick(2);
    chk("clr_viol", 8'(busy_viol), 8'h01);
    chk("clr_no_disp", 8'(disp_on), 8'h00);
    chk("clr_no_pulse", 8'(pulses), 8'h00);

    // Reset mid-clear restarts it and clears the sticky flag
    @(negedge clk); rst = 1'b1;
    tick(2);
    chk("rst2_viol", 8'(busy_viol), 8'h00);
    rst = 1'b0;
    tick(33);
    for (int i = 0; i < 32; i++) chk_char(5'(i), 8'h20);
    chk_status("idle_ac0", 1'b0, 8'h00);

    // Sequential data writes
    p0 = pulses;
    wr(1'b0, 8'h80);
    wr(1'b1, 8'h41);
    wr(1'b1, 8'h42);
    chk_char(5'd0, 8'h41);
    chk_char(5'd1, 8'h42);
    chk_status("ac_02", 1'b0, 8'h02);
    chk("pulses3", 8'(pulses - p0), 8'h03);
    chk("cmd_rs_data", 8'(cmd_rs), 8'h01);
    chk("cmd_byte_42", cmd_byte, 8'h42);

    // Line wrap 15 -> 16
    wr(1'b0, 8'h8F);
    wr(1'b1, 8'h5A);
    wr(1'b1, 8'h5B);
    chk_char(5'd15, 8'h5A);
    chk_char(5'd16, 8'h5B);
    chk_status("ac_41", 1'b0, 8'h41);

    // Back-to-back writes
    p0 = pulses;
    bus_write(1'b0, 8'hC0);
    tick(3);
    bus_write(1'b1, 8'h33);
    tick(GAP);
    chk("b2b_viol", 8'(busy_viol), EXP_VIOL);
    chk_char(5'd16, EXP_C16);
    chk("b2b_pulses", 8'(pulses - p0), 8'(EXP_PULSE));

    // Illegal address, then clear instruction
    wr(1'b0, 8'h90);
    chk("addr_err", 8'(addr_err), 8'h01);
    chk_status("ac_kept", 1'b0, EXP_AC);
    bus_write(1'b0, 8'h01);
    chk_status("clear_busy", 1'b0, 8'h80 | EXP_AC);
    tick(34);
    chk_char(5'd0, 8'h20);
    chk_char(5'd15, 8'h20);
    chk_char(5'd16, 8'h20);
    chk_char(5'd17, 8'h20);
    chk_char(5'd31, 8'h20);
    chk_status("clear_ac0", 1'b0, 8'h00);

    // Decrement order: 0 -> 31 and 16 -> 15
    wr(1'b0, 8'h04);
    chk("cmd_rs_instr", 8'(cmd_rs), 8'h00);
    chk("cmd_byte_04", cmd_byte, 8'h04);
    wr(1'b1, 8'h31);
    chk_char(5'd0, 8'h31);
    chk_status("ac_4f", 1'b0, 8'h4F);
    wr(1'b1, 8'h32);
    chk_char(5'd31, 8'h32);
    chk_status("ac_4e", 1'b0, 8'h4E);
    wr(1'b0, 8'hC0);
    wr(1'b1, 8'h55);
    chk_char(5'd16, 8'h55);
    chk_status("ac_0f", 1'b0, 8'h0F);

    // CGRAM mode discards data; home/function set/shift
    wr(1'b0, 8'h06);
    wr(1'b0, 8'h40);
    wr(1'b1, 8'h77);
    chk_char(5'd15, 8'h20);
    chk_status("cgram_ac", 1'b0, 8'h0F);
    wr(1'b0, 8'h02);
    wr(1'b0, 8'h38);
    wr(1'b0, 8'h1F);
    chk_status("home_ac", 1'b0, 8'h00);
    wr(1'b0, 8'h0C);
    chk("disp_on1", 8'(disp_on), 8'h01);
    wr(1'b0, 8'h08);
    chk("disp_on0", 8'(disp_on), 8'h00);

    // Same-index read during write returns the old byte
    wr(1'b0, 8'h80);
    @(negedge clk); rd_addr = 5'd0;
    bus_write(1'b1, 8'h7A);
    chk("rbw_old", rd_char, 8'h31);
    tick(1);
    chk("rbw_new", rd_char, 8'h7A);
    tick(GAP);
    chk_status("ac_01", 1'b0, 8'h01);

    // Data-register read and idle bus
    chk_status("rs1_read", 1'b1, 8'h00);
    @(negedge clk); lcd_rw = 1'b1;
    #1;
    chk("no_enb_oe", 8'(lcd_rdata_oe), 8'h00);
    chk("no_enb_data", lcd_rdata, 8'h00);
    lcd_rw = 1'b0;
    chk("addr_err_sticky", 8'(addr_err), 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_bus_decoder.md
LCD_BUS_DECODER -- requirements
Module: lcd_bus_decoder

Interface
REQ-001 The block SHALL have one clock `clk`; reset `rst` SHALL be synchronous and active-high.
REQ-002 Parameter `BUSY_CYCLES`, default 40: busy duration, in `clk` cycles, after any accepted write other than clear.
REQ-003 Port list (name, direction, width, meaning):
- `clk` — in, 1 — system clock (50 MHz)
- `rst` — in, 1 — synchronous active-high reset
- `lcd_enb` — in, 1 — LCD enable strobe from the controller
- `lcd_rs` — in, 1 — register select: 0 = instruction, 1 = data
- `lcd_rw` — in, 1 — 0 = write, 1 = read
- `lcd_data` — in, 8 — write data bus
- `lcd_rdata` — out, 8 — read data: {busy, AC[6:0]}
- `lcd_rdata_oe` — out, 1 — read drive enable
- `rd_addr` — in, 5 — display buffer read index, 0–31
- `rd_char` — out, 8 — character at `rd_addr`, registered, 1-cycle latency
- `cmd_valid` — out, 1 — one-cycle pulse per accepted bus write
- `cmd_rs` — out, 1 — RS of the accepted write
- `cmd_byte` — out, 8 — byte of the accepted write
- `disp_on` — out, 1 — display-on bit (D)
- `busy_viol` — out, 1 — sticky: a write arrived while busy
- `addr_err` — out, 1 — sticky: illegal DDRAM address

Function
REQ-004 `lcd_enb` SHALL be registered once. A write strobe SHALL be the registered 1→0 transition with `lcd_rw`=0; `lcd_rs` and `lcd_data` are sampled in that same cycle.
REQ-005 The state machine SHALL have the states IDLE, BUSY and CLEAR.
REQ-006 A strobe in IDLE SHALL be accepted. Acceptance pulses `cmd_valid` one cycle after the strobe, with `cmd_rs`/`cmd_byte` holding the sampled values.
REQ-007 Instruction decoding, priority highest bit first:
- 1xxxxxxx — set AC. 0x00–0x0F map to index 0–15; 0x40–0x4F map to index 16–31. Any other value sets `addr_err` and leaves AC unchanged.
- 01xxxxxx — CGRAM mode. Subsequent data writes are discarded until the next set-AC or clear.
- 001xxxxx — function set; no effect.
- 00001DCB — `disp_on` becomes D.
- 000001IS — the I/D bit is stored; S is ignored.
- 0000001x — AC becomes 0.
- 00000001 — enter CLEAR.
REQ-008 A data write SHALL store the byte at the current index, then step the index by ±1 according to I/D.
- Increment order wraps 15→16 and 31→0.
- Decrement order wraps 0→31 and 16→15.
REQ-009 CLEAR SHALL write 0x20 to one index per cycle, 0 through 31 (32 cycles), then set index 0 and I/D=1 and go to IDLE.
REQ-010 Every other accepted write SHALL go IDLE→BUSY for exactly `BUSY_CYCLES` cycles, then return to IDLE.
REQ-011 A strobe in BUSY or CLEAR SHALL set `busy_viol`, SHALL be discarded, and SHALL NOT pulse `cmd_valid`.
REQ-012 Busy flag = 1 in BUSY or CLEAR, else 0. AC[6:0] is the index mapped back to 0x00–0x0F / 0x40–0x4F.
REQ-013 While `lcd_enb`=1 and `lcd_rw`=1 and `lcd_rs`=0, `lcd_rdata_oe`=1 and `lcd_rdata` = {busy, AC} (combinational). Otherwise `lcd_rdata_oe`=0 and `lcd_rdata`=0. A read with `lcd_rs`=1 drives 0x00 with `lcd_rdata_oe`=1 and has no side effects.
REQ-014 A buffer write and a `rd_addr` read of the same index in the same cycle SHALL return the old value.

Reset
REQ-015 `rst` SHALL force:
- state := CLEAR (restarting any clear in progress);
- index := 0, I/D := 1, `disp_on` := 0, CGRAM mode := 0;
- `busy_viol` := 0, `addr_err` := 0, `cmd_valid` := 0, `cmd_rs` := 0, `cmd_byte` := 0x00;
- registered `lcd_enb` := 0, `rd_char` := 0x00.
REQ-016 The buffer SHALL read 0x20 everywhere 33 cycles after `rst` deasserts.
REQ-017 Strobes during the post-reset clear SHALL be handled per REQ-011.

Configuration
REQ-018 With macro `LCD_BUSY_EMU_EN` defined, busy timing SHALL follow REQ-010/REQ-011.
REQ-019 Without `LCD_BUSY_EMU_EN`:
- BUSY SHALL be removed; accepted non-clear writes stay in IDLE.
- The busy flag SHALL be 1 only during CLEAR.
- `busy_viol` SHALL be set only by strobes during CLEAR.

Structure
REQ-020 Package `lcd_pkg` SHALL hold:
- the state enum;
- instruction opcode masks and values;
- constants LCD_LINE1_BASE=0x00, LCD_LINE2_BASE=0x40, LCD_COLS=16, LCD_SPACE=0x20.
REQ-021 Sub-module `lcd_ddram` SHALL be a 32×8 storage block with one synchronous write port and one registered read port.

Verification
REQ-022 Release reset, wait 33 cycles → `rd_char` = 0x20 for all `rd_addr` 0–31; busy = 0.
REQ-023 Write cmd 0x80, then data 0x41, 0x42 (spacing > BUSY_CYCLES) → index 0 = 0x41, index 1 = 0x42, read AC = 0x02.
REQ-024 Write cmd 0x8F, data 0x5A, data 0x5B → index 15 = 0x5A, index 16 = 0x5B, AC = 0x41.
REQ-025 Write cmd 0xC0, then data 0x33 within 10 cycles → `busy_viol` = 1, index 16 unchanged, one `cmd_valid` pulse only.
REQ-026 Write cmd 0x90 → `addr_err` = 1, AC unchanged. Then cmd 0x01 → busy for 32 cycles, all indices = 0x20, AC = 0x00.
REQ-027 Write cmd 0x04 (I/D=0) at index 0, then data 0x31 → index 0 = 0x31, AC = 0x4F.
